// File: rtl/logic_gate_unit.sv
// Bitwise AND/OR/NOT gate block with zero-latency outputs and a
// registered copy that captures on en and clears asynchronously.
module logic_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             en,
    output logic [WIDTH-1:0] Y_and,
    output logic [WIDTH-1:0] Y_or,
    output logic [WIDTH-1:0] Y_not,
    output logic [WIDTH-1:0] Q_and,
    output logic [WIDTH-1:0] Q_or,
    output logic [WIDTH-1:0] Q_not,
    output logic             q_valid
);

    logic [WIDTH-1:0] and_d, and_q;
    logic [WIDTH-1:0] or_d, or_q;
    logic [WIDTH-1:0] not_d, not_q;
    logic             valid_d, valid_q;

    assign Y_and = A & B;
    assign Y_or  = A | B;
    assign Y_not = ~A;

    // Results hold while en is low; valid only marks a fresh capture.
    always_comb begin
        and_d   = and_q;
        or_d    = or_q;
        not_d   = not_q;
        valid_d = 1'b0;
        if (en) begin
            and_d   = Y_and;
            or_d    = Y_or;
            not_d   = Y_not;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_q   <= '0;
            or_q    <= '0;
            not_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            and_q   <= and_d;
            or_q    <= or_d;
            not_q   <= not_d;
            valid_q <= valid_d;
        end
    end

    assign Q_and   = and_q;
    assign Q_or    = or_q;
    assign Q_not   = not_q;
    assign q_valid = valid_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit at WIDTH=1 and WIDTH=4,
// using a per-bit truth-table reference model.
module tb_logic_gate_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       a1, b1;
    logic [3:0] a4, b4;

    logic       y1_and, y1_or, y1_not, q1_and, q1_or, q1_not, v1;
    logic [3:0] y4_and, y4_or, y4_not, q4_and, q4_or, q4_not;
    logic       v4;

    logic_gate_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .en(en),
        .Y_and(y1_and), .Y_or(y1_or), .Y_not(y1_not),
        .Q_and(q1_and), .Q_or(q1_or), .Q_not(q1_not),
        .q_valid(v1)
    );

    logic_gate_unit #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .en(en),
        .Y_and(y4_and), .Y_or(y4_or), .Y_not(y4_not),
        .Q_and(q4_and), .Q_or(q4_or), .Q_not(q4_not),
        .q_valid(v4)
    );

    int total = 0;
    int bad   = 0;

    // {and,or,not} per bit, indexed by {a,b}
    logic [2:0] tt [4];
    logic [2:0]  e1;
    logic [11:0] e4;
    logic        ev;

    function automatic logic [11:0] gates4(input logic [3:0] a,
                                           input logic [3:0] b);
        logic [3:0] ra, ro, rn;
        logic [2:0] t;
        for (int i = 0; i < 4; i++) begin
            t = tt[{a[i], b[i]}];
            ra[i] = t[2];
            ro[i] = t[1];
            rn[i] = t[0];
        end
        return {ra, ro, rn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":y1"}, 32'({y1_and, y1_or, y1_not}), 32'(tt[{a1, b1}]));
        chk({tag, ":y4"}, 32'({y4_and, y4_or, y4_not}), 32'(gates4(a4, b4)));
        chk({tag, ":q1"}, 32'({q1_and, q1_or, q1_not}), 32'(e1));
        chk({tag, ":q4"}, 32'({q4_and, q4_or, q4_not}), 32'(e4));
        chk({tag, ":v1"}, 32'(v1), 32'(ev));
        chk({tag, ":v4"}, 32'(v4), 32'(ev));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (en) begin
                e1 = tt[{a1, b1}];
                e4 = gates4(a4, b4);
                ev = 1'b1;
            end else begin
                ev = 1'b0;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        e1 = '0;
        e4 = '0;
        ev = 1'b0;
    endtask

    initial begin
        tt[0] = 3'b001;
        tt[1] = 3'b011;
        tt[2] = 3'b010;
        tt[3] = 3'b110;
        model_reset();
        rst = 1'b1;
        en  = 1'b0;
        a1  = 1'b1; b1 = 1'b0;
        a4  = 4'h3; b4 = 4'h5;
        #2;
        check_all("reset");

        en = 1'b1;
        a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
        repeat (2) begin
            tick();
            check_all("edge_in_reset");
        end
        rst = 1'b0;
        en  = 1'b0;

        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            a4 = 4'($urandom); b4 = 4'($urandom);
            tick();
            check_all("tt_en0");
        end

        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            a4 = 4'($urandom); b4 = 4'($urandom);
            tick();
            check_all("tt_en1");
        end
        chk("q11_and", 32'(q1_and), 32'd1);

        a1 = 1'b0; b1 = 1'b1;
        tick();
        check_all("hold_cap");
        en = 1'b0;
        a1 = 1'b1; b1 = 1'b0;
        repeat (3) begin
            tick();
            check_all("hold");
        end
        chk("hold_q_or", 32'(q1_or), 32'd1);
        chk("hold_q_not", 32'(q1_not), 32'd1);

        en = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        tick();
        check_all("pre_async");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");

        a1 = 1'b1; b1 = 1'b1;
        tick();
        check_all("held_rst");
        #2;
        rst = 1'b0;
        tick();
        check_all("release");
        chk("release_q_and", 32'(q1_and), 32'd1);
        chk("release_valid", 32'(v1), 32'd1);

        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        chk("w4_comb", 32'({y4_and, y4_or, y4_not}), 32'h8E3);
        tick();
        chk("w4_reg", 32'({q4_and, q4_or, q4_not}), 32'h8E3);

        repeat (200) begin
            en = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_rst");
                #1;
                rst = 1'b0;
            end else begin
                tick();
                check_all("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
